// File: rtl/seg_scroll_scanner_if.sv
// Write/offset-load bus between the message loader and seg_scroll_scanner.
// The master side owns the buffer write strobe and the window offset load.
interface seg_scroll_scanner_if #(
   parameter int unsigned ADDR_W = 4
) ();
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              offset_ld;
   logic [ADDR_W-1:0] offset_in;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data,
      output offset_ld,
      output offset_in
   );

   modport slave (
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  offset_ld,
      input  offset_in
   );
endinterface

// File: rtl/seg_scroll_scanner.sv
// N-digit multiplexed active-low 7-segment driver showing a hold/scroll/blink window of a message buffer.
// Define SEG_DIM_EN to add the brightness input and PWM dimming of the active anode.
module seg_scroll_scanner #(
   parameter int unsigned  NUM_DIGITS = 8,
   parameter int unsigned  MSG_LEN    = 16,
   parameter int unsigned  SCAN_DIV   = 31_250,
   parameter int unsigned  STEP_DIV   = 400,
   localparam int unsigned ADDR_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic                  clk,
   input  logic                  Resetn,
   input  logic                  en,
   input  logic [1:0]            mode,
   seg_scroll_scanner_if.slave   bus,
`ifdef SEG_DIM_EN
   input  logic [3:0]            brightness,
`endif
   output logic [NUM_DIGITS-1:0] AN,
   output logic [7:0]            CX,
   output logic [ADDR_W-1:0]     offset,
   output logic                  frame_tick,
   output logic                  step_tick
);

   localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned FRM_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SCAN_DIV - 1);
   localparam logic [DIG_W-1:0]  DIG_MAX  = DIG_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0]  FRM_MAX  = FRM_W'(STEP_DIV - 1);

   generate
      if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || MSG_LEN < 2 || MSG_LEN < NUM_DIGITS ||
          (MSG_LEN & (MSG_LEN - 1)) != 0 || SCAN_DIV < 1 || STEP_DIV < 1) begin : g_bad_params
         $error("seg_scroll_scanner: unsupported parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_LEFT  = 2'b01,
      MODE_RIGHT = 2'b10,
      MODE_BLINK = 2'b11
   } mode_e;

   typedef enum logic {
      PH_VISIBLE = 1'b0,
      PH_HIDDEN  = 1'b1
   } phase_e;

   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [DIG_W-1:0]      dig_q, dig_d;
   logic [FRM_W-1:0]      frm_q, frm_d;
   logic [ADDR_W-1:0]     off_q, off_d;
   mode_e                 mode_q, mode_d;
   phase_e                phase_q, phase_d;
   logic [7:0]            msg_q [MSG_LEN];
   logic [7:0]            msg_d [MSG_LEN];
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [7:0]            cx_q, cx_d;

   mode_e                 mode_in;
   logic                  slot_wrap;
   logic                  frame_now;
   logic                  step_now;
   logic                  pwm_on;
   logic [ADDR_W-1:0]     rd_addr;

`ifdef SEG_DIM_EN
   logic [3:0]            pwm_q, pwm_d;

   always_comb begin
      pwm_d  = en ? (pwm_q + 4'd1) : pwm_q;
      pwm_on = (pwm_q <= brightness);
   end
`else
   assign pwm_on = 1'b1;
`endif

   assign mode_in = mode_e'(mode);

   // Ticks are decoded from the counters so the step action lands on the same edge that ends the tick cycle.
   assign slot_wrap  = en && (slot_q == SLOT_MAX);
   assign frame_now  = slot_wrap && (dig_q == DIG_MAX);
   assign step_now   = frame_now && (frm_q == FRM_MAX);
   assign frame_tick = Resetn && frame_now;
   assign step_tick  = Resetn && step_now;

   always_comb begin
      slot_d  = slot_q;
      dig_d   = dig_q;
      frm_d   = frm_q;
      off_d   = off_q;
      mode_d  = mode_q;
      phase_d = phase_q;

      if (en) begin
         mode_d = mode_in;
         slot_d = slot_wrap ? '0 : (slot_q + SLOT_W'(1));
         if (slot_wrap) begin
            dig_d = (dig_q == DIG_MAX) ? '0 : (dig_q + DIG_W'(1));
         end
         if (frame_now) begin
            frm_d = step_now ? '0 : (frm_q + FRM_W'(1));
         end
         if (step_now) begin
            unique case (mode_in)
               MODE_LEFT:  off_d = off_q + ADDR_W'(1);
               MODE_RIGHT: off_d = off_q - ADDR_W'(1);
               MODE_BLINK: phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
               default:    off_d = off_q;
            endcase
         end
         // A mode change outranks a coincident blink toggle.
         if (mode_in != mode_q) begin
            phase_d = PH_VISIBLE;
         end
      end

      if (bus.offset_ld) begin
         off_d = bus.offset_in;
      end
   end

   always_comb begin
      msg_d = msg_q;
      if (bus.wr_en) begin
         msg_d[bus.wr_addr] = bus.wr_data;
      end
   end

   // Reads use msg_q, so a same-cycle write to the displayed address shows the old code once.
   always_comb begin
      rd_addr = off_q + ADDR_W'(dig_q);
      an_d    = '1;
      cx_d    = 8'hFF;
      if (en && (phase_q == PH_VISIBLE)) begin
         cx_d = msg_q[rd_addr];
         if (pwm_on) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
               if (dig_q == DIG_W'(NUM_DIGITS - 1 - i)) begin
                  an_d[i] = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!Resetn) begin
         slot_q  <= '0;
         dig_q   <= '0;
         frm_q   <= '0;
         off_q   <= '0;
         mode_q  <= MODE_HOLD;
         phase_q <= PH_VISIBLE;
         an_q    <= '1;
         cx_q    <= '1;
         for (int unsigned i = 0; i < MSG_LEN; i++) begin
            msg_q[i] <= '1;
         end
`ifdef SEG_DIM_EN
         pwm_q   <= '0;
`endif
      end else begin
         slot_q  <= slot_d;
         dig_q   <= dig_d;
         frm_q   <= frm_d;
         off_q   <= off_d;
         mode_q  <= mode_d;
         phase_q <= phase_d;
         an_q    <= an_d;
         cx_q    <= cx_d;
         msg_q   <= msg_d;
`ifdef SEG_DIM_EN
         pwm_q   <= pwm_d;
`endif
      end
   end

   assign AN     = an_q;
   assign CX     = cx_q;
   assign offset = off_q;

endmodule

// File: tb/tb_seg_scroll_scanner.sv
// Directed bench for seg_scroll_scanner with 4 digits, 8-entry buffer, 4 clk slots, 2 frames per step.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seg_scroll_scanner;

   logic       clk = 1'b0;
   logic       Resetn;
   logic       en;
   logic [1:0] mode;
   logic [3:0] AN;
   logic [7:0] CX;
   logic [2:0] offset;
   logic       frame_tick;
   logic       step_tick;
`ifdef SEG_DIM_EN
   logic [3:0] brightness;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   seg_scroll_scanner_if #(.ADDR_W(3)) bus_if ();

   seg_scroll_scanner #(
      .NUM_DIGITS(4),
      .MSG_LEN   (8),
      .SCAN_DIV  (4),
      .STEP_DIV  (2)
   ) dut (
      .clk       (clk),
      .Resetn    (Resetn),
      .en        (en),
      .mode      (mode),
      .bus       (bus_if),
`ifdef SEG_DIM_EN
      .brightness(brightness),
`endif
      .AN        (AN),
      .CX        (CX),
      .offset    (offset),
      .frame_tick(frame_tick),
      .step_tick (step_tick)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] an_for(input int unsigned dg);
      logic [3:0] one_hot;
      one_hot = 4'b1000 >> dg;
      return ~one_hot;
   endfunction

   task automatic do_reset();
      Resetn           = 1'b0;
      en               = 1'b0;
      mode             = 2'b00;
      bus_if.wr_en     = 1'b0;
      bus_if.wr_addr   = '0;
      bus_if.wr_data   = '0;
      bus_if.offset_ld = 1'b0;
      bus_if.offset_in = '0;
      repeat (3) tick();
      Resetn = 1'b1;
   endtask

   task automatic write_buf(input logic [2:0] a, input logic [7:0] d);
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = a;
      bus_if.wr_data = d;
      tick();
      bus_if.wr_en   = 1'b0;
   endtask

   task automatic write_codes();
      write_buf(3'd0, 8'h49);
      write_buf(3'd1, 8'h11);
      write_buf(3'd2, 8'h9F);
      write_buf(3'd3, 8'h71);
   endtask

   task automatic test_reset();
      Resetn           = 1'b0;
      en               = 1'b1;
      mode             = 2'b00;
      bus_if.wr_en     = 1'b1;
      bus_if.wr_addr   = 3'd0;
      bus_if.wr_data   = 8'h00;
      bus_if.offset_ld = 1'b1;
      bus_if.offset_in = 3'd5;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (AN !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b expected 1111", AN); end
         n_checks++;
         if (CX !== 8'hFF) begin n_fail++; $display("FAIL reset_cx got %h expected ff", CX); end
         n_checks++;
         if (offset !== 3'd0) begin n_fail++; $display("FAIL reset_offset got %0d expected 0", offset); end
         n_checks++;
         if (frame_tick !== 1'b0 || step_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_ticks got %b%b expected 00", frame_tick, step_tick);
         end
      end
      Resetn           = 1'b1;
      en               = 1'b0;
      bus_if.wr_en     = 1'b0;
      bus_if.offset_ld = 1'b0;
      tick();
      en = 1'b1;
      // Walk the window over addresses 0..3 then 4..7; every slot must read blank.
      for (int k = 1; k <= 32; k++) begin
         tick();
         n_checks++;
         if (AN !== an_for(((k - 1) / 4) % 4)) begin
            n_fail++; $display("FAIL reset_read_an k=%0d got %b expected %b", k, AN, an_for(((k - 1) / 4) % 4));
         end
         n_checks++;
         if (CX !== 8'hFF) begin n_fail++; $display("FAIL reset_read_cx k=%0d got %h expected ff", k, CX); end
         if (k == 16) begin
            bus_if.offset_ld = 1'b1;
            bus_if.offset_in = 3'd4;
         end else begin
            bus_if.offset_ld = 1'b0;
         end
      end
   endtask

   task automatic test_static_scan();
      logic [7:0] codes [4];
      int unsigned dg;
      codes = '{8'h49, 8'h11, 8'h9F, 8'h71};
      do_reset();
      write_codes();
      en = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         tick();
         dg = ((k - 1) / 4) % 4;
         n_checks++;
         if (AN !== an_for(dg)) begin n_fail++; $display("FAIL scan_an k=%0d got %b expected %b", k, AN, an_for(dg)); end
         n_checks++;
         if (CX !== codes[dg]) begin n_fail++; $display("FAIL scan_cx k=%0d got %h expected %h", k, CX, codes[dg]); end
         n_checks++;
         if (frame_tick !== ((k % 16) == 15)) begin
            n_fail++; $display("FAIL scan_frame_tick k=%0d got %b expected %b", k, frame_tick, ((k % 16) == 15));
         end
      end
   endtask

   task automatic test_scroll_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) write_buf(3'(i), 8'(8'h10 + i));
      mode             = 2'b01;
      bus_if.offset_ld = 1'b1;
      bus_if.offset_in = 3'd7;
      tick();
      bus_if.offset_ld = 1'b0;
      n_checks++;
      if (offset !== 3'd7) begin n_fail++; $display("FAIL load_offset got %0d expected 7", offset); end
      en = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k == 5) begin
            n_checks++;
            if (CX !== 8'h10) begin n_fail++; $display("FAIL window_wrap_cx got %h expected 10", CX); end
         end
         if (k == 31) begin
            n_checks++;
            if (step_tick !== 1'b1) begin n_fail++; $display("FAIL left_step_tick got %b expected 1", step_tick); end
            n_checks++;
            if (offset !== 3'd7) begin n_fail++; $display("FAIL left_pre_step got %0d expected 7", offset); end
         end
      end
      n_checks++;
      if (offset !== 3'd0) begin n_fail++; $display("FAIL left_wrap got %0d expected 0", offset); end
      mode = 2'b10;
      repeat (32) tick();
      n_checks++;
      if (offset !== 3'd7) begin n_fail++; $display("FAIL right_wrap got %0d expected 7", offset); end
      repeat (31) tick();
      n_checks++;
      if (step_tick !== 1'b1) begin n_fail++; $display("FAIL right_step_tick got %b expected 1", step_tick); end
      bus_if.offset_ld = 1'b1;
      bus_if.offset_in = 3'd3;
      tick();
      bus_if.offset_ld = 1'b0;
      n_checks++;
      if (offset !== 3'd3) begin n_fail++; $display("FAIL load_beats_step got %0d expected 3", offset); end
      tick();
      n_checks++;
      if (AN !== 4'b0111 || CX !== 8'h13) begin
         n_fail++; $display("FAIL offset_digit0 got %b/%h expected 0111/13", AN, CX);
      end
      repeat (4) tick();
      n_checks++;
      if (AN !== 4'b1011 || CX !== 8'h14) begin
         n_fail++; $display("FAIL offset_digit1 got %b/%h expected 1011/14", AN, CX);
      end
   endtask

   task automatic test_blink();
      do_reset();
      write_codes();
      mode = 2'b11;
      en   = 1'b1;
      for (int k = 1; k <= 99; k++) begin
         tick();
         if (k <= 32) begin
            n_checks++;
            if (AN !== an_for(((k - 1) / 4) % 4)) begin
               n_fail++; $display("FAIL blink_visible_an k=%0d got %b expected %b", k, AN, an_for(((k - 1) / 4) % 4));
            end
         end else if (k <= 64) begin
            n_checks++;
            if (AN !== 4'b1111 || CX !== 8'hFF) begin
               n_fail++; $display("FAIL blink_hidden k=%0d got %b/%h expected 1111/ff", k, AN, CX);
            end
         end else if (k == 65) begin
            n_checks++;
            if (AN !== 4'b0111 || CX !== 8'h49) begin
               n_fail++; $display("FAIL blink_reshow got %b/%h expected 0111/49", AN, CX);
            end
         end else if (k == 97) begin
            n_checks++;
            if (AN !== 4'b1111) begin n_fail++; $display("FAIL blink_hidden_again got %b expected 1111", AN); end
            mode = 2'b00;
         end else if (k == 99) begin
            n_checks++;
            if (AN !== 4'b0111 || CX !== 8'h49) begin
               n_fail++; $display("FAIL blink_mode_change got %b/%h expected 0111/49", AN, CX);
            end
         end
      end
   endtask

   task automatic test_enable_collision();
      do_reset();
      write_codes();
      en = 1'b1;
      repeat (5) tick();
      n_checks++;
      if (AN !== 4'b1011) begin n_fail++; $display("FAIL en_pre_an got %b expected 1011", AN); end
      en = 1'b0;
      tick();
      n_checks++;
      if (AN !== 4'b1111 || CX !== 8'hFF) begin
         n_fail++; $display("FAIL en_dark got %b/%h expected 1111/ff", AN, CX);
      end
      repeat (2) tick();
      n_checks++;
      if (offset !== 3'd0 || frame_tick !== 1'b0 || AN !== 4'b1111) begin
         n_fail++; $display("FAIL en_frozen got off=%0d ft=%b an=%b expected 0/0/1111", offset, frame_tick, AN);
      end
      en = 1'b1;
      tick();
      n_checks++;
      if (AN !== 4'b1011 || CX !== 8'h11) begin
         n_fail++; $display("FAIL en_resume got %b/%h expected 1011/11", AN, CX);
      end
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = 3'd1;
      bus_if.wr_data = 8'h24;
      tick();
      bus_if.wr_en = 1'b0;
      n_checks++;
      if (AN !== 4'b1011 || CX !== 8'h11) begin
         n_fail++; $display("FAIL collision_old got %b/%h expected 1011/11", AN, CX);
      end
      tick();
      n_checks++;
      if (AN !== 4'b1011 || CX !== 8'h24) begin
         n_fail++; $display("FAIL collision_new got %b/%h expected 1011/24", AN, CX);
      end
   endtask

`ifdef SEG_DIM_EN
   task automatic test_dimming();
      int unsigned lit;
      brightness = 4'd3;
      do_reset();
      write_codes();
      en = 1'b1;
      tick();
      lit = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (AN !== 4'b1111) lit++;
      end
      n_checks++;
      if (lit !== 4) begin n_fail++; $display("FAIL dim_b3 got %0d lit expected 4", lit); end
      brightness = 4'd15;
      lit = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (AN !== 4'b1111) lit++;
      end
      n_checks++;
      if (lit !== 16) begin n_fail++; $display("FAIL dim_b15 got %0d lit expected 16", lit); end
   endtask
`endif

   initial begin
`ifdef SEG_DIM_EN
      brightness = 4'd15;
`endif
      test_reset();
      test_static_scan();
      test_scroll_wrap();
      test_blink();
      test_enable_collision();
`ifdef SEG_DIM_EN
      test_dimming();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scroll_scanner.md
Name: seg_scroll_scanner

Overview:
Parametrised successor to the fixed 4-digit pattern multiplexer. It drives an N-digit multiplexed active-low 7-segment display from a writable message buffer. Internal prescalers generate the digit-scan and step rates. The display window can be held, scrolled left or right with wrap-around, or blinked. It sits between the top-level control logic (switches, message loader) and the board's AN/CX pins, and replaces the separate clock dividers, 2-bit counters and hard-coded mux.

Parameters:
NUM_DIGITS, 8, number of physical digits (1..8).
MSG_LEN, 16, message buffer depth in characters; power of two, >= NUM_DIGITS.
SCAN_DIV, 31_250, clk cycles per digit slot (100 MHz / 8 digits -> 400 Hz frame).
STEP_DIV, 400, frames per step tick (1 s at defaults).

Ports:
clk  input  1  system clock
Resetn  input  1  synchronous active-low reset
en  input  1  1 = run; 0 = freeze counters, display dark
mode  input  2  00 hold, 01 scroll left, 10 scroll right, 11 blink
wr_en  input  1  buffer write strobe
wr_addr  input  log2(MSG_LEN)  buffer write address
wr_data  input  8  segment code, CX format {a,b,c,d,e,f,g,dp}, 0 = lit
offset_ld  input  1  load window offset
offset_in  input  log2(MSG_LEN)  offset value to load
AN  output  NUM_DIGITS  digit anodes, active low, one-hot-low
CX  output  8  segment cathodes, active low
offset  output  log2(MSG_LEN)  current window offset
frame_tick  output  1  one-clk pulse at the end of each full scan frame
step_tick  output  1  one-clk pulse on each step

Behaviour:
- One clock domain: clk. Reset is synchronous, active-low (Resetn sampled on posedge clk); all state updates on posedge clk.
- Reset: AN = all 1, CX = 8'hFF, offset = 0, slot counter / digit index / frame counter = 0, blink phase = visible, ticks = 0, every buffer entry = 8'hFF (blank).
- Reset mid-operation: takes effect on the next edge and overrides en, wr_en and offset_ld.
- Slot counter: counts 0..SCAN_DIV-1 while en = 1. On wrap, digit index d advances 0..NUM_DIGITS-1 and wraps.
- frame_tick: asserted in the cycle d wraps from NUM_DIGITS-1 to 0.
- Frame counter: counts frame_ticks 0..STEP_DIV-1. On wrap it asserts step_tick for one clk.
- Digit mapping: d = 0 is the leftmost digit and drives AN[NUM_DIGITS-1]. Digit d shows buf[(offset + d) mod MSG_LEN].
- Output registers: AN and CX are registered and reflect d and buffer contents from the previous cycle (1-clk latency).
- Anodes: exactly one AN bit is low while en = 1 and the display is visible.
- Step actions (on step_tick):
  - mode 01: offset <= offset + 1 mod MSG_LEN (MSG_LEN-1 -> 0).
  - mode 10: offset <= offset - 1 mod MSG_LEN (0 -> MSG_LEN-1).
  - mode 00: offset unchanged.
  - mode 11: offset unchanged; blink phase toggles.
- Blink: when blink phase = hidden, AN = all 1 and CX = 8'hFF. Any mode change forces blink phase = visible on the next edge.
- offset_ld: offset <= offset_in on the next edge. If offset_ld and a scroll step_tick occur in the same cycle, the load wins.
- Writes: wr_en writes buf[wr_addr] <= wr_data on the next edge; writes are accepted regardless of en.
  - Write and read of the same address in the same cycle: the displayed value is the old data; the new data appears from the next read.
- en = 0: all counters, d, offset and blink phase hold; AN = all 1, CX = 8'hFF; no ticks are issued. On en returning to 1, scanning resumes from the held state.
- Widths: offset arithmetic is modulo 2^log2(MSG_LEN); no saturation anywhere.

Optional Feature:
SEG_DIM_EN
- Defined: adds input port brightness [3:0] and a free-running 4-bit PWM counter, incremented each clk while en = 1 and reset to 0. The active AN bit is driven low only when pwm_cnt <= brightness.
  - brightness = 15: full duty.
  - brightness = 0: 1/16 duty.
  - CX is unaffected. Scan, step and blink timing are unchanged.
- Undefined: the brightness port is absent; full duty always.

Test Plan:
Test parameters: NUM_DIGITS = 4, MSG_LEN = 8, SCAN_DIV = 4, STEP_DIV = 2.
1. Reset: hold Resetn = 0 for 3 clk with wr_en = 1 and en = 1 -> AN = 4'b1111, CX = 8'hFF, offset = 0, no ticks; a subsequent read of every address shows 8'hFF.
2. Static scan: write buf[0..3] = 8'h49, 8'h11, 8'h9F, 8'h71; en = 1, mode = 00.
   - AN steps 0111 -> 1011 -> 1101 -> 1110, each held for 4 clk.
   - CX = 49, 11, 9F, 71 respectively, each 1 clk after the digit index changes.
   - frame_tick pulses every 16 clk.
3. Scroll wrap: mode = 01, offset_ld with offset_in = 7.
   - After one step_tick (32 clk) offset = 0.
   - mode = 10 from offset = 0: after one step_tick offset = 7.
   - offset_ld = 1 with offset_in = 3 coincident with step_tick -> offset = 3.
4. Blink: mode = 11 -> after the 1st step_tick AN = 1111 and CX = FF for 32 clk; after the 2nd the display is visible again. Switching to mode = 00 while hidden -> visible on the next edge.
5. Enable / collision: en = 0 mid-slot -> AN = 1111 next cycle and offset frozen; en = 1 resumes the same digit. A write to the address being displayed shows the old code that cycle and the new code thereafter.
6. SEG_DIM_EN, brightness = 3: the active AN bit is low for exactly 4 of every 16 clk; brightness = 15 -> always low.
